// File: rtl/demux_sched.sv
// Round-robin burst demultiplexer: one serial input stream is handed to
// one of four sink channels for BURST bits at a time.
module demux_sched #(
  parameter int BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [3:0] ch_mask,
  input  logic [3:0] ch_ready,
  output logic [3:0] dout,
  output logic [3:0] dout_valid,
  output logic [1:0] sel,
  output logic       busy,
  output logic       burst_done
);

  localparam int CW = $clog2(BURST);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t        state;
  logic [1:0]    sel_q;
  logic [1:0]    last_grant;
  logic [1:0]    grant;
  logic [1:0]    cand;
  logic [CW-1:0] cnt;
  logic [3:0]    req;
  logic          found;
  logic          xfer;
  logic          last;

  assign req = ch_mask & ch_ready;

  // search starts one past the previous grant and wraps 3->0
  always_comb begin
    grant = last_grant;
    cand  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && req[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign din_ready = (state == XFER) && ch_ready[sel_q];
  assign xfer      = din_ready && din_valid;
  assign last      = (cnt == CW'(BURST - 1));
  assign busy      = (state == XFER);
  assign sel       = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= 2'b00;
      last_grant <= 2'b11;
      cnt        <= '0;
      dout       <= 4'b0000;
      dout_valid <= 4'b0000;
      burst_done <= 1'b0;
    end else begin
      dout       <= xfer ? (4'(din) << sel_q) : 4'b0000;
      dout_valid <= xfer ? (4'b0001 << sel_q) : 4'b0000;
      burst_done <= xfer && last;
      unique case (state)
        IDLE: begin
          if (|req) state <= ARB;
        end
        ARB: begin
          cnt <= '0;
          if (found) begin
            sel_q      <= grant;
            last_grant <= grant;
            state      <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (xfer) begin
            cnt <= cnt + CW'(1);
            if (last) state <= ARB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
